// File: rtl/apb2axi_rdf_mt.sv
// Multi-tag read data FIFO: one circular buffer per TAG so the APB side can
// drain outstanding TAGs in any order without head-of-line blocking.
module apb2axi_rdf_mt #(
    parameter int unsigned NUM_TAGS = 4,
    parameter int unsigned TAG_W    = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RESP_W   = 2,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                push_valid,
    output logic                push_ready,
    input  logic [TAG_W-1:0]    push_tag,
    input  logic [DATA_W-1:0]   push_data,
    input  logic [RESP_W-1:0]   push_resp,
    input  logic                push_last,
    input  logic                data_req,
    input  logic [TAG_W-1:0]    data_req_tag,
    output logic                data_valid,
    output logic [DATA_W-1:0]   data_out,
    output logic [RESP_W-1:0]   data_resp,
    output logic                data_last,
    output logic                data_underrun,
    input  logic                flush_valid,
    input  logic [TAG_W-1:0]    flush_tag,
    output logic [NUM_TAGS-1:0] tag_burst_ready,
    output logic [NUM_TAGS-1:0] tag_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = DATA_W + RESP_W + 1;

    if (TAG_W != $clog2(NUM_TAGS)) begin : g_bad_tag_w
        $error("TAG_W must equal clog2(NUM_TAGS)");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end

    // Entry layout: {data, resp, last}; storage is intentionally not reset
    logic [ENT_W-1:0] r_mem [NUM_TAGS][DEPTH];

    logic [PTR_W-1:0] r_wr_ptr [NUM_TAGS];
    logic [PTR_W-1:0] r_rd_ptr [NUM_TAGS];
    logic [CNT_W-1:0] r_count  [NUM_TAGS];
    logic [CNT_W-1:0] r_bursts [NUM_TAGS];

    logic                w_push_in_range;
    logic                w_req_in_range;
    logic                w_flush_in_range;
    logic                w_push_full;
    logic                w_push_flushed;
    logic                w_push_fire;
    logic                w_pop_fire;
    logic                w_flush_fire;
    logic [ENT_W-1:0]    w_pop_entry;
    logic                w_pop_last;
    logic [NUM_TAGS-1:0] w_push_hit;
    logic [NUM_TAGS-1:0] w_pop_hit;
    logic [NUM_TAGS-1:0] w_flush_hit;

    assign w_push_in_range  = (32'(push_tag) < NUM_TAGS);
    assign w_req_in_range   = (32'(data_req_tag) < NUM_TAGS);
    assign w_flush_in_range = (32'(flush_tag) < NUM_TAGS);

    // Readiness looks only at pre-pop occupancy; a same-cycle pop does not free the slot
    assign w_push_full    = (r_count[push_tag] == CNT_W'(DEPTH));
    assign w_push_flushed = flush_valid && (flush_tag == push_tag);
    assign push_ready     = w_push_in_range && !w_push_full && !w_push_flushed;
    assign w_push_fire    = push_valid && push_ready;

    assign w_pop_fire   = data_req && w_req_in_range && (r_count[data_req_tag] != '0);
    assign w_pop_entry  = r_mem[data_req_tag][r_rd_ptr[data_req_tag]];
    assign w_pop_last   = w_pop_entry[0];
    assign w_flush_fire = flush_valid && w_flush_in_range;

    // Per-TAG event decode and status flags
    always_comb begin
        w_push_hit      = '0;
        w_pop_hit       = '0;
        w_flush_hit     = '0;
        tag_empty       = '0;
        tag_burst_ready = '0;
        for (int unsigned t = 0; t < NUM_TAGS; t++) begin
            w_push_hit[t]      = w_push_fire  && (push_tag     == TAG_W'(t));
            w_pop_hit[t]       = w_pop_fire   && (data_req_tag == TAG_W'(t));
            w_flush_hit[t]     = w_flush_fire && (flush_tag    == TAG_W'(t));
            tag_empty[t]       = (r_count[t] == '0);
            tag_burst_ready[t] = (r_bursts[t] != '0);
        end
    end

    // Pointer, occupancy and burst bookkeeping; flush wins over push/pop updates
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int unsigned t = 0; t < NUM_TAGS; t++) begin
                r_wr_ptr[t] <= '0;
                r_rd_ptr[t] <= '0;
                r_count[t]  <= '0;
                r_bursts[t] <= '0;
            end
        end else begin
            for (int unsigned t = 0; t < NUM_TAGS; t++) begin
                if (w_flush_hit[t]) begin
                    r_wr_ptr[t] <= '0;
                    r_rd_ptr[t] <= '0;
                    r_count[t]  <= '0;
                    r_bursts[t] <= '0;
                end else begin
                    if (w_push_hit[t]) begin
                        r_wr_ptr[t] <= r_wr_ptr[t] + PTR_W'(1);
                    end
                    if (w_pop_hit[t]) begin
                        r_rd_ptr[t] <= r_rd_ptr[t] + PTR_W'(1);
                    end
                    r_count[t]  <= r_count[t] + CNT_W'(w_push_hit[t]) - CNT_W'(w_pop_hit[t]);
                    r_bursts[t] <= r_bursts[t]
                                   + CNT_W'(w_push_hit[t] && push_last)
                                   - CNT_W'(w_pop_hit[t] && w_pop_last);
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_push_fire) begin
            r_mem[push_tag][r_wr_ptr[push_tag]] <= {push_data, push_resp, push_last};
        end
    end

    // Pop response register; payload holds its value when nothing is popped
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_valid    <= 1'b0;
            data_underrun <= 1'b0;
            data_out      <= '0;
            data_resp     <= '0;
            data_last     <= 1'b0;
        end else begin
            data_valid    <= w_pop_fire;
            data_underrun <= data_req && !w_pop_fire;
            if (w_pop_fire) begin
                data_out  <= w_pop_entry[ENT_W-1 -: DATA_W];
                data_resp <= w_pop_entry[RESP_W:1];
                data_last <= w_pop_last;
            end
        end
    end

endmodule

// File: tb/tb_apb2axi_rdf_mt.sv
// Scoreboard bench for apb2axi_rdf_mt: stimulus queues expected pop responses,
// a negedge monitor pops and compares them whenever the DUT responds.
module tb_apb2axi_rdf_mt;

    localparam int unsigned NUM_TAGS = 4;
    localparam int unsigned TAG_W    = 2;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RESP_W   = 2;
    localparam int unsigned DEPTH    = 8;

    logic                PCLK;
    logic                PRESETn;
    logic                push_valid;
    logic                push_ready;
    logic [TAG_W-1:0]    push_tag;
    logic [DATA_W-1:0]   push_data;
    logic [RESP_W-1:0]   push_resp;
    logic                push_last;
    logic                data_req;
    logic [TAG_W-1:0]    data_req_tag;
    logic                data_valid;
    logic [DATA_W-1:0]   data_out;
    logic [RESP_W-1:0]   data_resp;
    logic                data_last;
    logic                data_underrun;
    logic                flush_valid;
    logic [TAG_W-1:0]    flush_tag;
    logic [NUM_TAGS-1:0] tag_burst_ready;
    logic [NUM_TAGS-1:0] tag_empty;

    apb2axi_rdf_mt #(
        .NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W), .DATA_W(DATA_W),
        .RESP_W(RESP_W), .DEPTH(DEPTH)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .push_valid(push_valid), .push_ready(push_ready), .push_tag(push_tag),
        .push_data(push_data), .push_resp(push_resp), .push_last(push_last),
        .data_req(data_req), .data_req_tag(data_req_tag),
        .data_valid(data_valid), .data_out(data_out), .data_resp(data_resp),
        .data_last(data_last), .data_underrun(data_underrun),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .tag_burst_ready(tag_burst_ready), .tag_empty(tag_empty)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } exp_t;

    exp_t sb[$];

    int st_tests, st_fail, mon_tests, mon_fail;
    int total_tests, total_fail;

    logic [31:0] hold_d;
    logic [1:0]  hold_r;
    logic        hold_l;

    // Monitor: every data_valid/data_underrun pulse must match the next queued expectation
    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESETn) begin
            hold_d = '0;
            hold_r = '0;
            hold_l = 1'b0;
        end else begin
            if (data_valid && data_underrun) begin
                mon_fail++;
                $display("FAIL valid_and_underrun both high at %0t", $time);
            end else if (data_valid || data_underrun) begin
                if (sb.size() == 0) begin
                    mon_fail++;
                    $display("FAIL unexpected_response valid=%0b underrun=%0b data=%h", data_valid, data_underrun, data_out);
                end else begin
                    e = sb.pop_front();
                    mon_tests++;
                    if (e.v) begin
                        hold_d = e.d;
                        hold_r = e.r;
                        hold_l = e.l;
                    end
                    if (data_valid !== e.v) begin
                        mon_fail++;
                        $display("FAIL resp_kind act_valid=%0b exp_valid=%0b", data_valid, e.v);
                    end else if (data_out !== hold_d || data_resp !== hold_r || data_last !== hold_l) begin
                        mon_fail++;
                        $display("FAIL resp_payload act=%h/%0d/%0b exp=%h/%0d/%0b",
                                 data_out, data_resp, data_last, hold_d, hold_r, hold_l);
                    end
                end
            end
            for (int t = 0; t < int'(NUM_TAGS); t++) begin
                if (int'(dut.r_count[t]) > int'(DEPTH) || int'(dut.r_bursts[t]) > int'(dut.r_count[t])) begin
                    mon_fail++;
                    $display("FAIL invariant tag=%0d count=%0d bursts=%0d", t, dut.r_count[t], dut.r_bursts[t]);
                end
            end
        end
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle();
        push_valid  = 1'b0;
        data_req    = 1'b0;
        flush_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        st_tests++;
        if (act !== exp) begin
            st_fail++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic exp_pop(input logic [31:0] d, input logic [1:0] r, input logic l);
        exp_t e;
        e.v = 1'b1; e.d = d; e.r = r; e.l = l;
        sb.push_back(e);
    endtask

    task automatic exp_under();
        exp_t e;
        e.v = 1'b0; e.d = '0; e.r = '0; e.l = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push(input logic [1:0] tag, input logic [31:0] d, input logic [1:0] r, input logic l);
        push_valid = 1'b1;
        push_tag   = tag;
        push_data  = d;
        push_resp  = r;
        push_last  = l;
        #1;
        chk("push_ready", 32'(push_ready), 32'd1);
        step();
        push_valid = 1'b0;
    endtask

    task automatic pop(input logic [1:0] tag, input logic [31:0] d, input logic [1:0] r, input logic l);
        data_req     = 1'b1;
        data_req_tag = tag;
        exp_pop(d, r, l);
        step();
        data_req = 1'b0;
    endtask

    task automatic under(input logic [1:0] tag);
        data_req     = 1'b1;
        data_req_tag = tag;
        exp_under();
        step();
        data_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] nxt_pop;
        logic [31:0] nxt_push;
        st_tests = 0; st_fail = 0; mon_tests = 0; mon_fail = 0;
        push_valid = 0; push_tag = '0; push_data = '0; push_resp = '0; push_last = 0;
        data_req = 0; data_req_tag = '0; flush_valid = 0; flush_tag = '0;
        PRESETn = 1'b1;
        #1 PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_underrun", 32'(data_underrun), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_empty", 32'(tag_empty), 32'hF);
        chk("rst_burst", 32'(tag_burst_ready), 32'h0);
        PRESETn = 1'b1;
        step();

        // Single TAG burst in, burst out
        for (int i = 0; i < 4; i++) begin
            push(2'd1, 32'h11 + 32'(i), 2'b00, i == 3);
            if (i == 2) chk("burst1_before_last", 32'(tag_burst_ready[1]), 32'd0);
        end
        chk("burst1_after_push", 32'(tag_burst_ready[1]), 32'd1);
        chk("empty1_after_push", 32'(tag_empty[1]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pop(2'd1, 32'h11 + 32'(i), 2'b00, i == 3);
            if (i == 2) chk("burst1_mid_pop", 32'(tag_burst_ready[1]), 32'd1);
        end
        chk("burst1_after_pop", 32'(tag_burst_ready[1]), 32'd0);
        chk("empty1_after_pop", 32'(tag_empty[1]), 32'd1);

        // Out-of-order drain across TAGs
        push(2'd0, 32'hA0, 2'b00, 1'b0);
        push(2'd2, 32'hB0, 2'b01, 1'b1);
        push(2'd0, 32'hA1, 2'b10, 1'b1);
        chk("burst_map_interleave", 32'(tag_burst_ready), 32'h5);
        pop(2'd2, 32'hB0, 2'b01, 1'b1);
        pop(2'd0, 32'hA0, 2'b00, 1'b0);
        pop(2'd0, 32'hA1, 2'b10, 1'b1);
        chk("all_empty", 32'(tag_empty), 32'hF);

        // Full TAG3, simultaneous pop+push, then wrap-around
        for (int i = 0; i < 8; i++) begin
            d = 32'h30 + 32'(i);
            push(2'd3, d, 2'b11, d[0]);
        end
        chk("burst3_full", 32'(tag_burst_ready[3]), 32'd1);
        push_tag = 2'd3;
        #1 chk("ready_full_tag3", 32'(push_ready), 32'd0);
        push_tag = 2'd0;
        #1 chk("ready_other_tag0", 32'(push_ready), 32'd1);
        push_valid = 1'b1; push_tag = 2'd3; push_data = 32'h38; push_resp = 2'b11; push_last = 1'b0;
        data_req = 1'b1; data_req_tag = 2'd3;
        exp_pop(32'h30, 2'b11, 1'b0);
        #1 chk("ready_full_with_pop", 32'(push_ready), 32'd0);
        step();
        idle();
        push(2'd3, 32'h38, 2'b11, 1'b0);
        nxt_pop  = 32'h31;
        nxt_push = 32'h39;
        for (int i = 0; i < 20; i++) begin
            pop(2'd3, nxt_pop, 2'b11, nxt_pop[0]);
            nxt_pop++;
            push(2'd3, nxt_push, 2'b11, nxt_push[0]);
            nxt_push++;
        end
        for (int i = 0; i < 8; i++) begin
            pop(2'd3, nxt_pop, 2'b11, nxt_pop[0]);
            nxt_pop++;
        end
        chk("empty3_drained", 32'(tag_empty[3]), 32'd1);
        chk("burst3_drained", 32'(tag_burst_ready[3]), 32'd0);

        // Underrun, and no same-cycle bypass
        under(2'd2);
        push_valid = 1'b1; push_tag = 2'd2; push_data = 32'h2A; push_resp = 2'b00; push_last = 1'b1;
        data_req = 1'b1; data_req_tag = 2'd2;
        exp_under();
        #1 chk("ready_tag2_bypass", 32'(push_ready), 32'd1);
        step();
        idle();
        pop(2'd2, 32'h2A, 2'b00, 1'b1);

        // Flush blocks same-cycle push and clears status
        push(2'd0, 32'h01, 2'b00, 1'b0);
        push(2'd0, 32'h02, 2'b00, 1'b0);
        push(2'd0, 32'h03, 2'b00, 1'b1);
        chk("burst0_before_flush", 32'(tag_burst_ready[0]), 32'd1);
        flush_valid = 1'b1; flush_tag = 2'd0;
        push_valid = 1'b1; push_tag = 2'd0; push_data = 32'h04; push_resp = 2'b00; push_last = 1'b0;
        #1 chk("ready_during_flush", 32'(push_ready), 32'd0);
        step();
        idle();
        chk("empty0_after_flush", 32'(tag_empty[0]), 32'd1);
        chk("burst0_after_flush", 32'(tag_burst_ready[0]), 32'd0);
        under(2'd0);
        push(2'd0, 32'h05, 2'b01, 1'b1);
        flush_valid = 1'b1; flush_tag = 2'd0;
        data_req = 1'b1; data_req_tag = 2'd0;
        exp_pop(32'h05, 2'b01, 1'b1);
        step();
        idle();
        chk("empty0_flush_pop", 32'(tag_empty[0]), 32'd1);
        under(2'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) begin
            push(2'd1, 32'h51 + 32'(i), 2'b00, i == 4);
        end
        pop(2'd1, 32'h51, 2'b00, 1'b0);
        @(negedge PCLK);
        #1;
        chk("valid_before_reset", 32'(data_valid), 32'd1);
        PRESETn = 1'b0;
        #1;
        chk("async_rst_valid", 32'(data_valid), 32'd0);
        chk("async_rst_data", data_out, 32'd0);
        chk("async_rst_empty", 32'(tag_empty), 32'hF);
        chk("async_rst_burst", 32'(tag_burst_ready), 32'h0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        step();
        under(2'd1);
        repeat (3) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        total_tests = st_tests + mon_tests;
        total_fail  = st_fail + mon_fail;
        $display("[TB] %0d tests run, %0d failed", total_tests, total_fail);
        $finish;
    end

endmodule
